// File: rtl/spi_regfile_peripheral.sv
// SPI register-file peripheral: oversampled SPI slave on iclk driving a
// bank of write/readback registers and serialising read-only status words.
//
// Ports:
//   iclk        internal clock, all state on its rising edge
//   rst         synchronous active-high reset
//   sclk        external SPI clock (asynchronous, synchronised here)
//   serial_in   PICO data, MSB first, sampled on sclk rise
//   rd_regs     flattened read-only registers, k at address N_WR+1+k
//   serial_out  POCI data, shifter MSB while in a read frame
//   wr_regs     flattened write registers, j at address j+1
//   wr_strobe   one-cycle pulse per written register
//   busy        high while a frame is in progress
//   frame_err   one-cycle pulse when a frame times out mid-word
`timescale 1ns/1ps

module spi_regfile_peripheral #(
    parameter int DATA_W       = 8,
    parameter int ADDR_W       = 7,
    parameter int N_WR         = 3,
    parameter int N_RD         = 56,
    parameter int SYNC_STAGES  = 2,
    parameter int IDLE_TIMEOUT = 64
) (
    input  logic                     iclk,
    input  logic                     rst,
    input  logic                     sclk,
    input  logic                     serial_in,
    input  logic [N_RD*DATA_W-1:0]   rd_regs,
    output logic                     serial_out,
    output logic [N_WR*DATA_W-1:0]   wr_regs,
    output logic [N_WR-1:0]          wr_strobe,
    output logic                     busy,
    output logic                     frame_err
);

    localparam int CNT_W  = $clog2(DATA_W + 1);
    localparam int IDLE_W = $clog2(IDLE_TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, CMD, DATA} state_t;

    state_t state, state_n;

    logic [SYNC_STAGES-1:0] sclk_sync;
    logic [SYNC_STAGES-1:0] sin_sync;
    logic                   sclk_d;
    logic                   sclk_s;
    logic                   sin_s;
    logic                   rise_p;
    logic                   fall_p;
    logic                   any_edge;

    logic [CNT_W-1:0]  bit_cnt;
    logic [IDLE_W-1:0] idle_cnt;
    logic [DATA_W-1:0] shift;
    logic [DATA_W-1:0] shift_nxt;
    logic [ADDR_W-1:0] addr;
    logic [ADDR_W-1:0] addr_inc;
    logic [ADDR_W-1:0] cmd_addr;
    logic              cmd_rw;
    logic              rw;
    logic              word_done;
    logic              timeout;

    // Read map: 0 -> N_WR, then write regs, then read-only regs, else 0.
    function automatic logic [DATA_W-1:0] read_word(input logic [ADDR_W-1:0] a);
        logic [DATA_W-1:0] v;
        v = '0;
        if (a == '0)
            v = DATA_W'(N_WR);
        for (int j = 0; j < N_WR; j++)
            if (a == ADDR_W'(j + 1))
                v = wr_regs[j*DATA_W +: DATA_W];
        for (int k = 0; k < N_RD; k++)
            if (a == ADDR_W'(N_WR + 1 + k))
                v = rd_regs[k*DATA_W +: DATA_W];
        return v;
    endfunction

    always_ff @(posedge iclk) begin
        if (rst) begin
            sclk_sync <= '0;
            sin_sync  <= '0;
            sclk_d    <= 1'b0;
        end else begin
            sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], sclk};
            sin_sync  <= {sin_sync[SYNC_STAGES-2:0], serial_in};
            sclk_d    <= sclk_s;
        end
    end

    assign sclk_s    = sclk_sync[SYNC_STAGES-1];
    assign sin_s     = sin_sync[SYNC_STAGES-1];
    assign rise_p    = sclk_s & ~sclk_d;
    assign fall_p    = ~sclk_s & sclk_d;
    assign any_edge  = rise_p | fall_p;

    assign shift_nxt = {shift[DATA_W-2:0], sin_s};
    assign cmd_rw    = shift_nxt[DATA_W-1];
    assign cmd_addr  = shift_nxt[DATA_W-2 -: ADDR_W];
    assign addr_inc  = addr + ADDR_W'(1);
    assign word_done = rise_p && (bit_cnt == CNT_W'(DATA_W - 1));

    // An edge in the same cycle as expiry keeps the frame alive.
    assign timeout = (state != IDLE) && !any_edge &&
                     (idle_cnt == IDLE_W'(IDLE_TIMEOUT - 1));

    always_ff @(posedge iclk) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_n;
    end

    always_comb begin
        state_n = state;
        unique case (state)
            IDLE: if (rise_p) state_n = CMD;
            CMD: begin
                if (timeout)
                    state_n = IDLE;
                else if (word_done)
                    state_n = DATA;
            end
            DATA: if (timeout) state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge iclk) begin
        if (rst) begin
            bit_cnt   <= '0;
            idle_cnt  <= '0;
            shift     <= '0;
            addr      <= '0;
            rw        <= 1'b0;
            wr_regs   <= '0;
            wr_strobe <= '0;
            frame_err <= 1'b0;
        end else begin
            wr_strobe <= '0;
            frame_err <= 1'b0;

            if (state == IDLE || any_edge || timeout)
                idle_cnt <= '0;
            else
                idle_cnt <= idle_cnt + IDLE_W'(1);

            unique case (state)
                IDLE: begin
                    bit_cnt <= '0;
                    if (rise_p) begin
                        shift   <= shift_nxt;
                        bit_cnt <= CNT_W'(1);
                    end
                end
                CMD: begin
                    if (timeout) begin
                        bit_cnt   <= '0;
                        frame_err <= (bit_cnt != '0);
                    end else if (rise_p) begin
                        if (word_done) begin
                            rw      <= cmd_rw;
                            addr    <= cmd_addr;
                            bit_cnt <= '0;
                            shift   <= cmd_rw ? read_word(cmd_addr)
                                              : shift_nxt;
                        end else begin
                            shift   <= shift_nxt;
                            bit_cnt <= bit_cnt + CNT_W'(1);
                        end
                    end
                end
                DATA: begin
                    if (timeout) begin
                        bit_cnt   <= '0;
                        frame_err <= (bit_cnt != '0);
                    end else if (rise_p) begin
                        bit_cnt <= word_done ? '0 : bit_cnt + CNT_W'(1);
                        if (!rw)
                            shift <= shift_nxt;
                        if (word_done) begin
                            addr <= addr_inc;
                            if (rw) begin
                                shift <= read_word(addr_inc);
                            end else begin
                                for (int j = 0; j < N_WR; j++) begin
                                    if (addr == ADDR_W'(j + 1)) begin
                                        wr_regs[j*DATA_W +: DATA_W] <= shift_nxt;
                                        wr_strobe[j] <= 1'b1;
                                    end
                                end
                            end
                        end
                    end else if (fall_p && rw && bit_cnt != '0) begin
                        // The fall closing a word keeps the freshly loaded MSB.
                        shift <= {shift[DATA_W-2:0], 1'b0};
                    end
                end
                default: bit_cnt <= '0;
            endcase
        end
    end

    assign busy       = (state != IDLE);
    assign serial_out = (state == DATA) && rw && shift[DATA_W-1];

endmodule

// File: tb/tb_spi_regfile_peripheral.sv
// Testbench for spi_regfile_peripheral: table of SPI frames with a
// strobe/readback scoreboard, plus reset and timeout sequences.
`timescale 1ns/1ps

module tb_spi_regfile_peripheral;

    localparam int HALF = 8;
    localparam int NV   = 7;

    logic            iclk = 1'b0;
    logic            rst  = 1'b1;
    logic            sclk = 1'b0;
    logic            serial_in = 1'b0;
    logic [447:0]    rd_regs;
    logic            serial_out;
    logic [23:0]     wr_regs;
    logic [2:0]      wr_strobe;
    logic            busy;
    logic            frame_err;

    int total = 0;
    int bad   = 0;
    int ferr_cnt = 0;

    typedef struct {
        int idx;
        logic [7:0] d;
    } stb_t;

    typedef struct {
        logic [7:0]      cmd;
        int              nw;
        logic [4:0][7:0] dat;
        logic [4:0][3:0] stb;
        logic [23:0]     wr;
    } vec_t;

    stb_t       sq[$];
    logic [7:0] rq[$];
    vec_t       v[NV];
    stb_t       se;

    spi_regfile_peripheral dut (
        .iclk       (iclk),
        .rst        (rst),
        .sclk       (sclk),
        .serial_in  (serial_in),
        .rd_regs    (rd_regs),
        .serial_out (serial_out),
        .wr_regs    (wr_regs),
        .wr_strobe  (wr_strobe),
        .busy       (busy),
        .frame_err  (frame_err)
    );

    always #5 iclk = ~iclk;

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    always @(negedge iclk) begin
        if (!rst && frame_err)
            ferr_cnt++;
        if (!rst && wr_strobe != 3'b000) begin
            if (sq.size() == 0) begin
                chk("unexpected_strobe", 64'(wr_strobe), 64'h0);
            end else begin
                se = sq.pop_front();
                chk("strobe_bit", 64'(wr_strobe), 64'(3'b001 << se.idx));
                chk("strobe_data", 64'(wr_regs[se.idx*8 +: 8]), 64'(se.d));
            end
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge iclk);
        #1;
    endtask

    // Mode-0 master: drive on low phase, sample serial_out at the rise.
    task automatic spi_xfer(input logic [7:0] tx, input int nbits,
                            output logic [7:0] rx);
        rx = 8'h00;
        for (int i = 7; i > 7 - nbits; i--) begin
            serial_in = tx[i];
            step(HALF);
            rx[i] = serial_out;
            sclk = 1'b1;
            step(HALF);
            sclk = 1'b0;
        end
    endtask

    task automatic end_frame(input string name);
        step(80);
        chk(name, 64'(busy), 64'h0);
    endtask

    initial begin
        logic [7:0] rx;
        logic [7:0] e;
        int f0;

        for (int k = 0; k < 56; k++)
            rd_regs[k*8 +: 8] = 8'(k + 16);
        rd_regs[7:0]     = 8'h5A;
        rd_regs[447:440] = 8'hC7;

        foreach (v[i]) begin
            v[i].dat = '0;
            v[i].stb = '0;
        end
        v[0].cmd = 8'h01; v[0].nw = 3; v[0].wr = 24'hF03CA5;
        v[0].dat[0] = 8'hA5; v[0].stb[0] = 4'd1;
        v[0].dat[1] = 8'h3C; v[0].stb[1] = 4'd2;
        v[0].dat[2] = 8'hF0; v[0].stb[2] = 4'd3;
        v[1].cmd = 8'h80; v[1].nw = 5; v[1].wr = 24'hF03CA5;
        v[1].dat[0] = 8'h03; v[1].dat[1] = 8'hA5; v[1].dat[2] = 8'h3C;
        v[1].dat[3] = 8'hF0; v[1].dat[4] = 8'h5A;
        v[2].cmd = 8'hFF; v[2].nw = 2; v[2].wr = 24'hF03CA5;
        v[2].dat[0] = 8'h00; v[2].dat[1] = 8'h03;
        v[3].cmd = 8'h3B; v[3].nw = 1; v[3].wr = 24'hF03CA5;
        v[3].dat[0] = 8'h77;
        v[4].cmd = 8'h03; v[4].nw = 2; v[4].wr = 24'h113CA5;
        v[4].dat[0] = 8'h11; v[4].stb[0] = 4'd3;
        v[4].dat[1] = 8'h22;
        v[5].cmd = 8'h81; v[5].nw = 3; v[5].wr = 24'h113CA5;
        v[5].dat[0] = 8'hA5; v[5].dat[1] = 8'h3C; v[5].dat[2] = 8'h11;
        v[6].cmd = 8'hBB; v[6].nw = 2; v[6].wr = 24'h113CA5;
        v[6].dat[0] = 8'hC7; v[6].dat[1] = 8'h00;

        step(3);
        rst = 1'b0;
        step(1);
        chk("rst_wr_regs", 64'(wr_regs), 64'h0);
        chk("rst_busy", 64'(busy), 64'h0);
        chk("rst_serial_out", 64'(serial_out), 64'h0);
        chk("rst_strobe", 64'(wr_strobe), 64'h0);
        chk("rst_frame_err", 64'(frame_err), 64'h0);

        spi_xfer(8'h01, 5, rx);
        chk("busy_mid_cmd", 64'(busy), 64'h1);
        rst = 1'b1;
        step(3);
        rst = 1'b0;
        step(1);
        chk("midrst_busy", 64'(busy), 64'h0);
        chk("midrst_serial_out", 64'(serial_out), 64'h0);
        chk("midrst_wr_regs", 64'(wr_regs), 64'h0);
        end_frame("midrst_idle");
        chk("midrst_no_ferr", 64'(ferr_cnt), 64'h0);

        for (int f = 0; f < NV; f++) begin
            spi_xfer(v[f].cmd, 8, rx);
            for (int w = 0; w < v[f].nw; w++) begin
                if (v[f].cmd[7]) begin
                    rq.push_back(v[f].dat[w]);
                    spi_xfer(8'h00, 8, rx);
                    e = rq.pop_front();
                    chk($sformatf("rd_f%0d_w%0d", f, w), 64'(rx), 64'(e));
                end else begin
                    if (v[f].stb[w] != 4'd0)
                        sq.push_back('{idx: int'(v[f].stb[w]) - 1,
                                       d: v[f].dat[w]});
                    spi_xfer(v[f].dat[w], 8, rx);
                end
            end
            end_frame($sformatf("idle_f%0d", f));
            chk($sformatf("strobes_left_f%0d", f), 64'(sq.size()), 64'h0);
            chk($sformatf("wr_regs_f%0d", f), 64'(wr_regs), 64'(v[f].wr));
        end
        chk("no_ferr_normal", 64'(ferr_cnt), 64'h0);

        f0 = ferr_cnt;
        spi_xfer(8'h02, 8, rx);
        chk("busy_in_data", 64'(busy), 64'h1);
        spi_xfer(8'hFF, 4, rx);
        end_frame("timeout_idle");
        chk("timeout_ferr", 64'(ferr_cnt - f0), 64'h1);
        chk("timeout_wr1", 64'(wr_regs[15:8]), 64'h3C);
        chk("timeout_nostrobe", 64'(sq.size()), 64'h0);

        sq.push_back('{idx: 1, d: 8'h5C});
        spi_xfer(8'h02, 8, rx);
        spi_xfer(8'h5C, 8, rx);
        end_frame("post_timeout_idle");
        chk("post_timeout_strobes", 64'(sq.size()), 64'h0);
        chk("post_timeout_wr", 64'(wr_regs), 64'h115CA5);

        spi_xfer(8'h82, 8, rx);
        spi_xfer(8'h00, 8, rx);
        chk("post_timeout_rd", 64'(rx), 64'h5C);
        end_frame("post_timeout_rd_idle");

        f0 = ferr_cnt;
        spi_xfer(8'h80, 3, rx);
        end_frame("cmd_timeout_idle");
        chk("cmd_timeout_ferr", 64'(ferr_cnt - f0), 64'h1);
        chk("cmd_timeout_wr", 64'(wr_regs), 64'h115CA5);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: bench did not finish");
        $fatal(1, "watchdog");
    end

endmodule
